modn_chain_counter: RTL and testbench
=====================================

Name: modn_chain_counter

Overview:
Parametrised multi-digit modulo-N counter, the successor to the single-stage mod-N counter. Cascades NUM_DIGITS identical mod-DIGIT_N stages with ripple-free, synchronous carry. Adds up/down counting, parallel load, a one-shot/wrap mode select and registered wrap/done status. Used for BCD event counters, timers and display drivers in the Counters library.

Parameters:
NUM_DIGITS, 4, number of cascaded stages (>=1)
DIGIT_N, 10, modulus of every stage (>=2)
DW, max(1,$clog2(DIGIT_N)), bits per digit (derived; not overridden)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  count enable, one step per cycle while high
up_dn  input  1  1 = count up, 0 = count down
load  input  1  parallel-load strobe
load_value  input  NUM_DIGITS*DW  load data, digit i at [i*DW +: DW], digit 0 = least significant
oneshot  input  1  1 = stop at terminal count, 0 = wrap
count  output  NUM_DIGITS*DW  current value, same digit packing as load_value
tc  output  1  combinational: all digits at terminal value for the current up_dn
carry_out  output  1  combinational: tc & enable; cascades into a further counter
wrap  output  1  registered one-cycle pulse after a wrap edge
done  output  1  registered sticky flag in oneshot mode

Behaviour:
- Reset: count = 0 (all digits), wrap = 0, done = 0. Reset overrides load and enable.
- Priority per edge: reset > load > enable. enable low with no load: count, done hold; wrap = 0.
- Load: each digit is taken from load_value. A digit >= DIGIT_N is clamped to DIGIT_N-1. done clears to 0 and wrap = 0 on the load edge's following cycle.
- Digit terminal value: DIGIT_N-1 when up_dn = 1; 0 when up_dn = 0. It uses the current cycle's up_dn.
- Stage i steps when enable = 1 and stages 0..i-1 are all terminal. Stage 0 steps on enable alone.
- Step rules:
  - Up: d = (d == N-1) ? 0 : d+1.
  - Down: d = (d == 0) ? N-1 : d-1.
  - All stages update on the same edge; there is no ripple.
- tc = AND over all digits of digit-terminal. It is independent of enable.
- Wrap mode (oneshot = 0): on an edge with enable = 1 and tc = 1, the whole count wraps (all-max -> 0 up, 0 -> all-max down). wrap = 1 for exactly the next cycle. done stays 0.
- Oneshot mode (oneshot = 1): on an edge with enable = 1 and tc = 1, count holds and done <= 1. done stays 1 until reset or load. wrap is never asserted.
- Oneshot with done = 1 and tc = 0: this happens only if up_dn is flipped. Counting resumes normally, and done stays sticky.
- Changing up_dn or oneshot mid-count takes effect on the next edge. No pipeline flush is needed.
- Latency: count reflects enable/load one cycle after the sampling edge. tc and carry_out are combinational from count/up_dn/enable.
- NUM_DIGITS = 1 degenerates to a single up/down mod-N stage with load.

Decomposition:
- Package modn_pkg:
  - function clog2_min1
  - localparams for up/down encodings (DIR_UP = 1, DIR_DN = 0)
  - function digit_terminal(d, up_dn, N)
- Sub-module modn_digit: one stage, ports clk, reset, load, ld_val, step, up_dn, d, term.
  - Instantiated NUM_DIGITS times in a generate loop.
  - step chain = enable & AND(term[0..i-1]).
- Top level holds the tc/carry_out logic, the oneshot hold gating of step, and the wrap/done registers.

Test Plan:
- Default params with NUM_DIGITS = 2, up, wrap mode, enable high from reset -> count steps 00..99. tc = 1 only at 99. The next edge gives 00 and wrap = 1 for exactly one cycle.
- Down from reset -> first edge 99 with wrap pulse, then 98, 97. tc = 1 at 00 before the edge. carry_out = tc & enable.
- Load digits {4,7} (value 47) with enable = 1 on the same cycle -> count = 47, not 48. Load digit values {12,3} -> clamped to 93.
- Oneshot up from 95 -> 96..99, then holds at 99 with done = 1 and wrap = 0 for 5 more enables. A load of 00 clears done.
- Reset asserted with load = 1 and enable = 1 mid-count at 63 -> next cycle count = 00, done = 0, wrap = 0.
- enable toggled 1-0-1 with up_dn flipped during a low cycle at 50 -> sequence 50, 50 (hold), 49. Per-digit carry is checked at digit boundary 40->39.

Source files
------------

// File: rtl/modn_pkg.sv
// Shared helpers for the cascaded modulo-N counter: digit width derivation,
// direction encodings and the per-digit terminal-value test.
package modn_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int clog2_min1(input int n);
    int w;
    w = 0;
    while ((32'sd1 << w) < n) begin
      w = w + 32'sd1;
    end
    return (w < 32'sd1) ? 32'sd1 : w;
  endfunction

  // A digit is terminal at N-1 when counting up and at 0 when counting down.
  function automatic logic digit_terminal(input int unsigned d, input logic up_dn,
                                          input int unsigned n);
    if (up_dn == DIR_UP) begin
      return (d == n - 32'd1);
    end else begin
      return (d == 32'd0);
    end
  endfunction

endpackage

// File: rtl/modn_digit.sv
// One mod-N stage: synchronous reset, clamped parallel load, up/down step
// gated by the carry chain built in the parent.
module modn_digit
  import modn_pkg::*;
#(
  parameter int N  = 10,
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [DW-1:0] ld_val,
  input  logic          step,
  input  logic          up_dn,
  output logic [DW-1:0] d,
  output logic          term
);

  localparam logic [DW-1:0] MAX_D = DW'(N - 1);

  logic [DW-1:0] r_d;

  // Out-of-range load data saturates to the largest legal digit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_d <= '0;
    end else if (load) begin
      r_d <= (ld_val > MAX_D) ? MAX_D : ld_val;
    end else if (step) begin
      if (up_dn == DIR_UP) begin
        r_d <= (r_d == MAX_D) ? '0 : r_d + DW'(1);
      end else begin
        r_d <= (r_d == '0) ? MAX_D : r_d - DW'(1);
      end
    end
  end

  assign d    = r_d;
  assign term = digit_terminal(32'(r_d), up_dn, 32'(N));

endmodule

// File: rtl/modn_chain_counter.sv
// Multi-digit up/down mod-N counter: digits share one edge and advance via a
// combinational carry chain; top level adds oneshot hold and wrap/done status.
module modn_chain_counter
  import modn_pkg::*;
#(
  parameter  int NUM_DIGITS = 4,
  parameter  int DIGIT_N    = 10,
  localparam int DW         = clog2_min1(DIGIT_N)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     up_dn,
  input  logic                     load,
  input  logic [NUM_DIGITS*DW-1:0] load_value,
  input  logic                     oneshot,
  output logic [NUM_DIGITS*DW-1:0] count,
  output logic                     tc,
  output logic                     carry_out,
  output logic                     wrap,
  output logic                     done
);

  logic [NUM_DIGITS-1:0] w_term;
  logic [NUM_DIGITS-1:0] w_step;
  logic                  w_tc;
  logic                  w_hold;
  logic                  r_wrap;
  logic                  r_done;

  assign w_tc   = &w_term;
  // In oneshot mode the terminal count freezes every stage instead of wrapping.
  assign w_hold = oneshot & w_tc;

  assign w_step[0] = enable & ~w_hold;
  for (genvar i = 1; i < NUM_DIGITS; i++) begin : g_chain
    assign w_step[i] = w_step[i-1] & w_term[i-1];
  end

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    modn_digit #(
      .N  (DIGIT_N),
      .DW (DW)
    ) u_digit (
      .clk    (clk),
      .reset  (reset),
      .load   (load),
      .ld_val (load_value[i*DW +: DW]),
      .step   (w_step[i]),
      .up_dn  (up_dn),
      .d      (count[i*DW +: DW]),
      .term   (w_term[i])
    );
  end

  // Wrap pulses for one cycle after a wrapping step; done is sticky until load/reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrap <= 1'b0;
      r_done <= 1'b0;
    end else if (load) begin
      r_wrap <= 1'b0;
      r_done <= 1'b0;
    end else if (enable) begin
      r_wrap <= w_tc & ~oneshot;
      r_done <= r_done | w_hold;
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign tc        = w_tc;
  assign carry_out = w_tc & enable;
  assign wrap      = r_wrap;
  assign done      = r_done;

endmodule

// File: tb/tb_modn_chain_counter.sv
// Self-checking bench: two BCD digits modelled as an integer 0..99 with
// modular arithmetic; directed scenarios plus randomized traffic.
module tb_modn_chain_counter;

  localparam int ND = 2;
  localparam int N  = 10;
  localparam int DW = 4;
  localparam int W  = ND * DW;
  localparam int MAXV = 99;

  logic         clk = 1'b0;
  logic         reset, enable, up_dn, load, oneshot;
  logic [W-1:0] load_value, count;
  logic         tc, carry_out, wrap, done;

  int errors = 0;
  int checks = 0;

  int mv;
  bit mwrap, mdone;

  modn_chain_counter #(.NUM_DIGITS(ND), .DIGIT_N(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .up_dn      (up_dn),
    .load       (load),
    .load_value (load_value),
    .oneshot    (oneshot),
    .count      (count),
    .tc         (tc),
    .carry_out  (carry_out),
    .wrap       (wrap),
    .done       (done)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] enc(input int v);
    logic [W-1:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model state update from the inputs present at the rising edge.
  task automatic model_step();
    int d0, d1;
    bit term;
    if (reset) begin
      mv = 0; mwrap = 0; mdone = 0;
    end else if (load) begin
      d0 = int'(load_value[3:0]);
      d1 = int'(load_value[7:4]);
      if (d0 > 9) d0 = 9;
      if (d1 > 9) d1 = 9;
      mv = d1 * 10 + d0;
      mwrap = 0; mdone = 0;
    end else if (enable) begin
      term = up_dn ? (mv == MAXV) : (mv == 0);
      if (term && oneshot) begin
        mdone = 1; mwrap = 0;
      end else begin
        mwrap = term;
        mv = up_dn ? (mv + 1) % (MAXV + 1) : (mv + MAXV) % (MAXV + 1);
      end
    end else begin
      mwrap = 0;
    end
  endtask

  task automatic compare_all();
    bit etc;
    etc = up_dn ? (mv == MAXV) : (mv == 0);
    chk("count", 32'(count), 32'(enc(mv)));
    chk("tc", 32'(tc), 32'(etc));
    chk("carry_out", 32'(carry_out), 32'(etc & enable));
    chk("wrap", 32'(wrap), 32'(mwrap));
    chk("done", 32'(done), 32'(mdone));
  endtask

  task automatic cyc(input logic rst, input logic en, input logic ud, input logic ld,
                     input logic [W-1:0] lv, input logic os);
    reset = rst; enable = en; up_dn = ud; load = ld; load_value = lv; oneshot = os;
    #1;
    compare_all();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; up_dn = 1'b1; load = 1'b0;
    load_value = 8'h00; oneshot = 1'b0;
    @(posedge clk);
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
    chk("reset_count", 32'(count), 32'h00);
    chk("reset_wrap", 32'(wrap), 32'h0);
    chk("reset_done", 32'(done), 32'h0);

    // Count up 00..99, then wrap.
    for (int i = 0; i < 99; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    #1;
    chk("up_at99", 32'(count), 32'h99);
    chk("up_tc99", 32'(tc), 32'h1);
    chk("model_at99", 32'(enc(mv)), 32'h99);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    #1;
    chk("up_wrap_cnt", 32'(count), 32'h00);
    chk("up_wrap_pulse", 32'(wrap), 32'h1);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    #1;
    chk("up_after_wrap", 32'(count), 32'h01);
    chk("wrap_one_cycle", 32'(wrap), 32'h0);

    // Down from reset.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    #1;
    chk("dn_first", 32'(count), 32'h99);
    chk("dn_wrap", 32'(wrap), 32'h1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    #1;
    chk("dn_97", 32'(count), 32'h97);

    // Load beats enable; clamping of an oversized digit.
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 8'h47, 1'b0);
    #1;
    chk("load47", 32'(count), 32'h47);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'hC3, 1'b0);
    #1;
    chk("load_clamp93", 32'(count), 32'h93);
    chk("model_clamp93", 32'(enc(mv)), 32'h93);

    // Oneshot up from 95.
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'h95, 1'b1);
    for (int i = 0; i < 9; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
    #1;
    chk("os_hold99", 32'(count), 32'h99);
    chk("os_done", 32'(done), 32'h1);
    chk("os_nowrap", 32'(wrap), 32'h0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1);
    #1;
    chk("os_load_clr", 32'(done), 32'h0);

    // Reset overrides load and enable.
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'h63, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'h63, 1'b0);
    #1;
    chk("rst_over_load", 32'(count), 32'h00);

    // Enable 1-0-1 with direction flip while idle, then a digit borrow.
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 8'h50, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    #1;
    chk("hold50", 32'(count), 32'h50);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    #1;
    chk("dn49", 32'(count), 32'h49);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h40, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    #1;
    chk("borrow39", 32'(count), 32'h39);

    // Randomized traffic against the model.
    begin
      logic ud, os;
      ud = 1'b1; os = 1'b0;
      for (int i = 0; i < 1500; i++) begin
        if ($urandom_range(7, 0) == 0) ud = ~ud;
        if ($urandom_range(15, 0) == 0) os = ~os;
        cyc(($urandom_range(63, 0) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(3, 0) != 0) ? 1'b1 : 1'b0,
            ud,
            ($urandom_range(15, 0) == 0) ? 1'b1 : 1'b0,
            W'($urandom),
            os);
      end
      cyc(1'b0, 1'b0, ud, 1'b0, 8'h00, os);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
